// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register with a valid/ready handshake and a
// 2-entry skid buffer (main + skid). Upstream ready is a function of registered
// state plus the bubble/flush/stall controls only, so it never depends on
// in_valid or out_ready.
//
// Also provides:
//   - hold (stall): blocks dequeue only; the stage keeps accepting while it has room
//   - bubble-insert: refuses new input for the cycle
//   - flush: kills every held beat
//   - configurable flush-versus-stall priority
//   - saturating count of consecutive stall cycles
//
// Parameters:
//   WIDTH            payload width in bits
//   CNT_W            width of stall_cnt
//   FLUSH_OVER_STALL 1 = flush wins over stall; 0 = stall wins, flush is dropped
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active-low
//   in_valid   in   upstream payload valid
//   in_data    in   upstream payload [WIDTH]
//   in_ready   out  stage can accept a beat this cycle
//   out_valid  out  main entry valid (registered)
//   out_data   out  main entry payload (registered) [WIDTH]
//   out_ready  in   downstream accepts
//   stall      in   hold; blocks dequeue
//   bubble     in   hazard; refuse input this cycle
//   flush      in   kill all held beats
//   stall_cnt  out  consecutive stall cycles, saturating [CNT_W]
//   occupancy  out  entries held: 0, 1 or 2
//
// Build option:
//   PIPE_STAGE_CLR_DATA_EN  when defined, any entry that is invalidated has its
//                           payload register cleared, so out_data reads 0
//                           whenever out_valid is 0. When undefined, stale
//                           payloads are kept (fewer register toggles).
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int WIDTH            = 64,
  parameter int CNT_W            = 64,
  parameter int FLUSH_OVER_STALL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             stall,
  input  logic             bubble,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic FOS = (FLUSH_OVER_STALL != 0);

`ifdef PIPE_STAGE_CLR_DATA_EN
  localparam logic CLR_DATA = 1'b1;
`else
  localparam logic CLR_DATA = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   main_reg, main_next;
  logic [WIDTH-1:0]   skid_reg, skid_next;
  logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;

  logic flush_eff;
  logic acc;
  logic deq;

  // With stall priority, a flush that coincides with a stall is dropped
  // outright (not remembered for later).
  assign flush_eff = flush & (FOS | ~stall);

  // No path from in_valid or out_ready: only registered state and the
  // bubble/flush(/stall) controls.
  assign in_ready  = (state_reg != ST_FULL) & ~bubble & ~flush_eff;
  assign acc       = in_valid & in_ready;

  // Outputs come straight off the state and payload registers.
  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = main_reg;
  assign occupancy = state_reg;
  assign stall_cnt = stall_cnt_reg;

  assign deq = out_valid & out_ready & ~stall;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;

    if (flush_eff) begin
      // in_ready is already low here, so nothing can be accepted this cycle.
      state_next = ST_EMPTY;
      if (CLR_DATA) begin
        main_next = '0;
        skid_next = '0;
      end
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (acc) begin
            state_next = ST_ONE;
            main_next  = in_data;
          end
        end
        ST_ONE: begin
          if (acc && deq) begin
            main_next = in_data;
          end else if (acc) begin
            // Downstream not taking (or stalled): park the new beat behind main.
            state_next = ST_FULL;
            skid_next  = in_data;
          end else if (deq) begin
            state_next = ST_EMPTY;
            if (CLR_DATA) begin
              main_next = '0;
            end
          end
        end
        ST_FULL: begin
          // Skid always drains into main so ordering is preserved.
          if (deq) begin
            state_next = ST_ONE;
            main_next  = skid_reg;
            if (CLR_DATA) begin
              skid_next = '0;
            end
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // Consecutive-stall counter: saturates at all-ones, cleared by a cycle
  // without stall or by an effective flush.
  always_comb begin
    stall_cnt_next = '0;
    if (!flush_eff && stall) begin
      if (stall_cnt_reg != CNT_MAX) begin
        stall_cnt_next = stall_cnt_reg + CNT_ONE;
      end else begin
        stall_cnt_next = stall_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances of pipe_stage_reg:
//   u_a : WIDTH=64, CNT_W=64, FLUSH_OVER_STALL=0 (stream, skid, bubble, flush,
//         async reset). Its output beats are checked against a scoreboard queue
//         filled when the bench drives a beat that must be accepted.
//   u_b : WIDTH=64, CNT_W=3,  FLUSH_OVER_STALL=1 (counter saturation,
//         flush overriding stall).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// or on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic        a_stall, a_bubble, a_flush;
  logic [63:0] a_in_data, a_out_data, a_stall_cnt;
  logic [1:0]  a_occ;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_stall, b_bubble, b_flush;
  logic [63:0] b_in_data, b_out_data;
  logic [2:0]  b_stall_cnt;
  logic [1:0]  b_occ;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [63:0] sb[$];
  logic [63:0] sb_exp;

  pipe_stage_reg #(.WIDTH(64), .CNT_W(64), .FLUSH_OVER_STALL(0)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .stall(a_stall), .bubble(a_bubble), .flush(a_flush),
    .stall_cnt(a_stall_cnt), .occupancy(a_occ)
  );

  pipe_stage_reg #(.WIDTH(64), .CNT_W(3), .FLUSH_OVER_STALL(1)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .stall(b_stall), .bubble(b_bubble), .flush(b_flush),
    .stall_cnt(b_stall_cnt), .occupancy(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A beat leaves u_a at the next rising edge when this holds on the falling edge.
  always @(negedge clk) begin
    if (reset && a_out_valid && a_out_ready && !a_stall && !a_flush) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", a_out_data, 64'hDEAD_BEEF);
      end else begin
        sb_exp = sb.pop_front();
        chk("sb_data", a_out_data, sb_exp);
      end
    end
  end

  initial begin
    reset = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_stall = 0; a_bubble = 0; a_flush = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_stall = 0; b_bubble = 0; b_flush = 0;
    repeat (2) step();

    // ---- reset state ----
    chk("rst_out_valid", 64'(a_out_valid), 64'h0);
    chk("rst_out_data",  a_out_data,       64'h0);
    chk("rst_occ",       64'(a_occ),       64'h0);
    chk("rst_stall_cnt", a_stall_cnt,      64'h0);
    chk("rst_in_ready",  64'(a_in_ready),  64'h1);
    chk("rst_b_cnt",     64'(b_stall_cnt), 64'h0);
    reset = 1'b1;

    // ---- stream 0x11, 0x22, 0x33 with out_ready=1 ----
    a_out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1;
      a_in_data  = 64'(i * 8'h11);
      sb.push_back(64'(i * 8'h11));
      step();
      $display("stream beat 0x%0h", 64'(i * 8'h11));
      chk("stream_valid", 64'(a_out_valid), 64'h1);
      chk("stream_data",  a_out_data,       64'(i * 8'h11));
      chk("stream_occ",   64'(a_occ),       64'h1);
      chk("stream_ready", 64'(a_in_ready),  64'h1);
    end
    a_in_valid = 0;
    step();
    chk("stream_drain_occ", 64'(a_occ), 64'h0);

    // ---- skid fill under stall ----
    a_stall = 1; a_in_valid = 1; a_in_data = 64'hA; sb.push_back(64'hA);
    step();
    $display("skid: accept 0xA under stall");
    chk("skid_cnt1", a_stall_cnt, 64'd1);
    chk("skid_occ1", 64'(a_occ),  64'd1);
    a_in_data = 64'hB; sb.push_back(64'hB);
    step();
    $display("skid: accept 0xB under stall");
    chk("skid_cnt2",  a_stall_cnt,      64'd2);
    chk("skid_occ2",  64'(a_occ),       64'd2);
    chk("skid_ready", 64'(a_in_ready),  64'h0);
    a_in_data = 64'hC;
    step();
    $display("skid: 0xC refused while full");
    chk("skid_cnt3",  a_stall_cnt,      64'd3);
    chk("skid_occ3",  64'(a_occ),       64'd2);
    chk("skid_main",  a_out_data,       64'hA);
    a_stall = 0;
    #1;
    chk("skid_ready_full", 64'(a_in_ready), 64'h0);
    step();
    $display("skid: release, 0xA out");
    chk("skid_cnt0",  a_stall_cnt,      64'd0);
    chk("skid_occ_r", 64'(a_occ),       64'd1);
    chk("skid_mainB", a_out_data,       64'hB);
    sb.push_back(64'hC);
    step();
    $display("skid: 0xB out, 0xC accepted");
    chk("skid_mainC", a_out_data,       64'hC);
    a_in_valid = 0;
    step();
    chk("skid_empty", 64'(a_occ), 64'd0);

    // ---- stall beats flush (FLUSH_OVER_STALL=0) ----
    a_stall = 1; a_in_valid = 1; a_in_data = 64'h1; sb.push_back(64'h1);
    step();
    a_in_data = 64'h2; sb.push_back(64'h2);
    step();
    a_in_valid = 0; a_flush = 1;
    #1;
    chk("fos0_ready", 64'(a_in_ready), 64'h0);
    step();
    $display("flush+stall on FOS=0: flush dropped");
    chk("fos0_occ",  64'(a_occ),  64'd2);
    chk("fos0_cnt",  a_stall_cnt, 64'd3);
    chk("fos0_data", a_out_data,  64'h1);
    a_flush = 0; a_stall = 0;
    repeat (2) step();
    chk("fos0_drain", 64'(a_occ), 64'd0);

    // ---- plain flush (no stall) on FOS=0 ----
    a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h77;
    step();
    a_in_data = 64'h78; a_flush = 1;
    #1;
    chk("flush_ready", 64'(a_in_ready), 64'h0);
    step();
    $display("flush without stall: beats killed");
    chk("flush_valid", 64'(a_out_valid), 64'h0);
    chk("flush_occ",   64'(a_occ),       64'd0);
    a_flush = 0; a_in_valid = 0;

    // ---- bubble ----
    a_in_valid = 1; a_in_data = 64'h55; sb.push_back(64'h55);
    step();
    a_out_ready = 1; a_bubble = 1; a_in_data = 64'h66;
    #1;
    chk("bub_ready", 64'(a_in_ready), 64'h0);
    step();
    $display("bubble: 0x55 out, 0x66 refused");
    chk("bub_valid", 64'(a_out_valid), 64'h0);
    chk("bub_occ",   64'(a_occ),       64'd0);
    a_bubble = 0; sb.push_back(64'h66);
    #1;
    chk("bub_ready2", 64'(a_in_ready), 64'h1);
    step();
    $display("bubble: 0x66 accepted");
    chk("bub_valid2", 64'(a_out_valid), 64'h1);
    chk("bub_data2",  a_out_data,       64'h66);
    a_in_valid = 0;
    step();

    // ---- saturation on CNT_W=3 ----
    b_stall = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      $display("sat cycle %0d stall_cnt %0d", i, b_stall_cnt);
      chk("sat_cnt", 64'(b_stall_cnt), 64'((i > 7) ? 7 : i));
    end

    // ---- flush beats stall (FLUSH_OVER_STALL=1) ----
    b_in_valid = 1; b_in_data = 64'h5A;
    step();
    b_in_data = 64'h5B;
    step();
    chk("fos1_full", 64'(b_occ),      64'd2);
    chk("fos1_main", b_out_data,      64'h5A);
    b_in_valid = 0; b_flush = 1;
    #1;
    chk("fos1_ready", 64'(b_in_ready), 64'h0);
    step();
    $display("flush+stall on FOS=1: flushed");
    chk("fos1_valid", 64'(b_out_valid), 64'h0);
    chk("fos1_occ",   64'(b_occ),       64'd0);
    chk("fos1_cnt",   64'(b_stall_cnt), 64'd0);
`ifdef PIPE_STAGE_CLR_DATA_EN
    chk("fos1_clr_data", b_out_data, 64'h0);
`endif
    b_flush = 0; b_stall = 0;
    #1;
    chk("fos1_ready2", 64'(b_in_ready), 64'h1);

    // ---- asynchronous reset while FULL ----
    a_stall = 1; a_out_ready = 1; a_in_valid = 1; a_in_data = 64'h91; sb.push_back(64'h91);
    step();
    a_in_data = 64'h92; sb.push_back(64'h92);
    step();
    a_in_valid = 0;
    chk("ar_full", 64'(a_occ), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    $display("async reset asserted mid-cycle");
    chk("ar_valid", 64'(a_out_valid), 64'h0);
    chk("ar_occ",   64'(a_occ),       64'd0);
    chk("ar_cnt",   a_stall_cnt,      64'd0);
    chk("ar_data",  a_out_data,       64'h0);
    sb.delete();
    a_stall = 0;
    step();
    reset = 1'b1;
    step();
    chk("ar_post_occ", 64'(a_occ), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register. It is the successor to the fixed decode/execute register and is used between any two pipeline stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, so upstream ready comes from registered state.
- Keeps hold (external stall), bubble-insert (hazard) and flush (jump/CSR) controls.
- Adds a configurable flush-versus-stall priority and a saturating counter of consecutive stall cycles.

Parameters:
WIDTH, 64, payload width in bits
CNT_W, 64, width of stall_cnt
FLUSH_OVER_STALL, 0, 1 = flush wins over stall; 0 = stall wins and the flush is dropped

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
in_valid  input  1  upstream payload valid
in_data  input  WIDTH  upstream payload
in_ready  output  1  stage can accept a beat this cycle
out_valid  output  1  main entry valid
out_data  output  WIDTH  main entry payload
out_ready  input  1  downstream accepts
stall  input  1  hold (memory handshake pending); blocks dequeue
bubble  input  1  hazard; refuse input this cycle
flush  input  1  kill all held beats (jump / CSR redirect)
stall_cnt  output  CNT_W  consecutive cycles with stall=1
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
Asynchronous reset (reset=0, effective immediately, independent of clk):
- state = EMPTY; out_valid = 0; out_data = 0; skid entry = 0; stall_cnt = 0; occupancy = 0.
- Assertion mid-transfer discards all beats.

Derived signals (combinational):
- flush_eff = flush & (FLUSH_OVER_STALL | ~stall).
- in_ready = (state != FULL) & ~bubble & ~flush_eff.
- acc = in_valid & in_ready.
- deq = out_valid & out_ready & ~stall.

States:
- EMPTY: occupancy 0; out_valid = 0.
- ONE: occupancy 1; main entry valid.
- FULL: occupancy 2; main and skid entries valid.

Transitions, each taking effect at the next edge:
- flush_eff: state → EMPTY from any state; both entries invalid; no acc in that cycle. Flush has highest priority.
- EMPTY: acc → ONE, main ← in_data.
- ONE:
  - acc & deq → ONE, main ← in_data.
  - acc & ~deq → FULL, skid ← in_data.
  - ~acc & deq → EMPTY.
  - otherwise hold.
- FULL: in_ready = 0. deq → ONE, main ← skid. Otherwise hold.

Rules:
- stall blocks only dequeue. An acc while stall=1 in state ONE fills the skid entry; no beat is lost or duplicated.
- When FLUSH_OVER_STALL = 0 and flush & stall in the same cycle, the flush is ignored, not deferred. The beat stays held, matching the previous-generation priority.
- bubble with no other event leaves the held beat untouched. Only new input is refused, which produces an invalid slot downstream.
- Order preserved: the skid entry always leaves after main.
- out_valid and out_data are driven directly from registers, with no combinational path from inputs.
- in_ready has combinational paths from bubble, flush and stall only (through flush_eff; stall affects it only when FLUSH_OVER_STALL = 0). It has none from in_valid or out_ready.
- stall_cnt: stall=1 → stall_cnt+1, saturating at all-ones with no wrap; stall=0 → 0. flush_eff also forces 0.

Optional Feature:
Macro PIPE_STAGE_CLR_DATA_EN.
- Defined: any entry that becomes invalid (flush_eff, dequeue to EMPTY, skid drained to main) has its payload register written to 0. out_data is 0 whenever out_valid = 0, which simplifies downstream debug and trace.
- Undefined: invalidated payloads keep stale values and only the valid bits clear (lower toggle power). out_data is don't-care while out_valid = 0.
- Reset value is 0 in both builds.

Test Plan:
- Reset/stream: release reset, then in_valid=1 with data 0x11, 0x22, 0x33 on consecutive cycles, out_ready=1 → out_data 0x11, 0x22, 0x33 one cycle later each; occupancy stays 1; in_ready stays 1.
- Skid fill under stall: stall=1 for 3 cycles while feeding 0xA, 0xB, 0xC → 0xA in main, 0xB in skid, in_ready=0, 0xC not accepted; stall_cnt = 1, 2, 3. On stall release: out 0xA, then 0xB, then 0xC; stall_cnt returns to 0.
- Flush priority:
  - FLUSH_OVER_STALL=0, FULL, flush=1 & stall=1 → occupancy stays 2.
  - FLUSH_OVER_STALL=1, same stimulus → out_valid=0, occupancy=0 next cycle, stall_cnt=0.
- Bubble: in state ONE holding 0x55, out_ready=1, bubble=1 for 1 cycle with in_valid=1, data 0x66 → in_ready=0, next cycle out_valid=0. 0x66 is accepted the following cycle.
- Counter saturation: CNT_W=3, stall=1 for 10 cycles → stall_cnt reaches 7 and stays at 7.
- Async reset mid-op: reset=0 between edges while FULL → out_valid=0 and occupancy=0 immediately (before next edge); with PIPE_STAGE_CLR_DATA_EN defined, out_data=0 after a flush.
